// File: rtl/buffer_drain_ctrl_pkg.sv
// Shared types and helpers for the accumulator window controller and drain stage.
package buffer_drain_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      ACC   = 2'd2
   } win_state_e;

   typedef enum logic {
      D_IDLE = 1'b0,
      D_SEND = 1'b1
   } drain_state_e;

   // Two's-complement result; the caller keeps the low bits it needs.
   function automatic logic [63:0] to_bipolar(input logic [63:0] count,
                                              input logic [63:0] winlen);
      return (count << 1) - winlen;
   endfunction

endpackage

// File: rtl/buffer_drain_ctrl_drain_serializer.sv
// Serial drain of a frozen accumulator bank: lane index counter, lane mux,
// optional bipolar conversion and valid/ready handshake.
module drain_serializer
   import buffer_drain_ctrl_pkg::*;
#(
   parameter int ODIM    = 16,
   parameter int OWID    = 32,
   parameter int WINLEN  = 256,
   parameter int BIPOLAR = 0,
   parameter int DWID    = OWID + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    launch,
   input  logic [OWID-1:0]         iData [ODIM],
   output logic                    oValid,
   input  logic                    iReady,
   output logic [$clog2(ODIM)-1:0] oIdx,
   output logic [DWID-1:0]         oData,
   output logic                    oOverrun
);

   localparam int IW = $clog2(ODIM);

   function automatic logic [DWID-1:0] convert(input logic [OWID-1:0] count);
      logic [63:0] wide;
      wide = '0;
      wide[OWID-1:0] = count;
      if (BIPOLAR != 0) begin
         wide = to_bipolar(wide, 64'(WINLEN));
      end
      return wide[DWID-1:0];
   endfunction

   drain_state_e    state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d, nxt_idx;
   logic            valid_q, valid_d;
   logic [DWID-1:0] data_q, data_d;
   logic            overrun_q, overrun_d;
   logic            transfer, last_lane;

   assign transfer  = valid_q & iReady;
   assign last_lane = (idx_q == IW'(ODIM - 1));

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      data_d    = data_q;
      overrun_d = overrun_q;
      nxt_idx   = idx_q + IW'(1);
      if (launch) begin
         // A final-lane transfer in the launch cycle completes the old drain cleanly.
         if (state_q == D_SEND && !(transfer && last_lane)) begin
            overrun_d = 1'b1;
         end
         state_d = D_SEND;
         idx_d   = '0;
         valid_d = 1'b1;
         data_d  = convert(iData[0]);
      end else if (state_q == D_SEND && transfer) begin
         if (last_lane) begin
            state_d = D_IDLE;
            valid_d = 1'b0;
         end else begin
            idx_d  = nxt_idx;
            data_d = convert(iData[nxt_idx]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= D_IDLE;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         overrun_q <= overrun_d;
      end
   end

   assign oValid   = valid_q;
   assign oIdx     = idx_q;
   assign oData    = data_q;
   assign oOverrun = overrun_q;

endmodule

// File: rtl/buffer_drain_ctrl.sv
// Window sequencer for the ping-pong accumulator array plus the serial drain
// of the bank frozen at each window end.
module buffer_drain_ctrl
   import buffer_drain_ctrl_pkg::*;
#(
   parameter int ODIM    = 16,
   parameter int OWID    = 32,
   parameter int WINLEN  = 256,
   parameter int BIPOLAR = 0,
   parameter int DWID    = OWID + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    iStart,
   input  logic [OWID-1:0]         iData [ODIM],
   output logic                    oAccSel,
   output logic                    oClear,
   output logic                    oValid,
   input  logic                    iReady,
   output logic [$clog2(ODIM)-1:0] oIdx,
   output logic [DWID-1:0]         oData,
   output logic                    oBusy,
   output logic                    oOverrun
);

   localparam int CW = (WINLEN > 1) ? $clog2(WINLEN) : 1;

   win_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_q, sel_d;
   logic          clear_q, clear_d;
   logic          busy_q, busy_d;
   logic          launch_q, launch_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      launch_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iStart) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_d = ACC;
            cnt_d   = '0;
         end
         ACC: begin
            if (cnt_q == CW'(WINLEN - 1)) begin
               // Launch is registered alongside the bank toggle so the drain
               // samples the frozen bank in the first cycle after the swap.
               cnt_d    = '0;
               sel_d    = ~sel_q;
               launch_d = 1'b1;
               state_d  = iStart ? CLEAR : IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      clear_d = (state_d == CLEAR);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sel_q    <= 1'b0;
         clear_q  <= 1'b0;
         busy_q   <= 1'b0;
         launch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         clear_q  <= clear_d;
         busy_q   <= busy_d;
         launch_q <= launch_d;
      end
   end

   assign oAccSel = sel_q;
   assign oClear  = clear_q;
   assign oBusy   = busy_q;

   drain_serializer #(
      .ODIM    (ODIM),
      .OWID    (OWID),
      .WINLEN  (WINLEN),
      .BIPOLAR (BIPOLAR),
      .DWID    (DWID)
   ) u_drain (
      .clk      (clk),
      .rst      (rst),
      .launch   (launch_q),
      .iData    (iData),
      .oValid   (oValid),
      .iReady   (iReady),
      .oIdx     (oIdx),
      .oData    (oData),
      .oOverrun (oOverrun)
   );

endmodule

// File: tb/tb_buffer_drain_ctrl.sv
// Scoreboard bench: a behavioural ping-pong accumulator and window-timing model
// predicts each drain; a negedge monitor checks both a unipolar and a bipolar DUT.
module tb_buffer_drain_ctrl;

   localparam int ODIM   = 4;
   localparam int OWID   = 8;
   localparam int WINLEN = 8;
   localparam int DWID   = OWID + 1;
   localparam int IW     = $clog2(ODIM);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            iStart = 1'b0;
   logic            iReady = 1'b0;
   logic [OWID-1:0] iData [ODIM];

   logic            sel_u, clr_u, val_u, busy_u, ovr_u;
   logic [IW-1:0]   idx_u;
   logic [DWID-1:0] data_u;
   logic            sel_b, clr_b, val_b, busy_b, ovr_b;
   logic [IW-1:0]   idx_b;
   logic [DWID-1:0] data_b;

   buffer_drain_ctrl #(
      .ODIM(ODIM), .OWID(OWID), .WINLEN(WINLEN), .BIPOLAR(0), .DWID(DWID)
   ) u_dut_uni (
      .clk(clk), .rst(rst), .iStart(iStart), .iData(iData),
      .oAccSel(sel_u), .oClear(clr_u), .oValid(val_u), .iReady(iReady),
      .oIdx(idx_u), .oData(data_u), .oBusy(busy_u), .oOverrun(ovr_u)
   );

   buffer_drain_ctrl #(
      .ODIM(ODIM), .OWID(OWID), .WINLEN(WINLEN), .BIPOLAR(1), .DWID(DWID)
   ) u_dut_bip (
      .clk(clk), .rst(rst), .iStart(iStart), .iData(iData),
      .oAccSel(sel_b), .oClear(clr_b), .oValid(val_b), .iReady(iReady),
      .oIdx(idx_b), .oData(data_b), .oBusy(busy_b), .oOverrun(ovr_b)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic longint exp_uni(input int c);
      return longint'(c);
   endfunction

   function automatic longint exp_bip(input int c);
      longint          v;
      logic [DWID-1:0] e;
      v = 2 * longint'(c) - WINLEN;
      e = v[DWID-1:0];
      return longint'(e);
   endfunction

   // Reference model state
   typedef struct {
      int idx;
      int cnt;
   } exp_t;

   exp_t q[$];
   int   bank [2][ODIM];
   int   bias [ODIM];
   int   win_pos = -1;   // -1 idle, 0 clear cycle, 1..WINLEN accumulate cycles
   int   msel = 0;
   bit   launch_pend = 1'b0;
   bit   exp_ovr = 1'b0;
   bit   mon_en = 1'b0;

   task automatic model_step();
      exp_t e;
      if (rst) begin
         win_pos     = -1;
         msel        = 0;
         launch_pend = 1'b0;
         exp_ovr     = 1'b0;
         q.delete();
         return;
      end
      if (launch_pend) begin
         if (q.size() != 0) exp_ovr = 1'b1;
         q.delete();
         for (int l = 0; l < ODIM; l++) begin
            e.idx = l;
            e.cnt = bank[msel ^ 1][l];
            q.push_back(e);
         end
         launch_pend = 1'b0;
      end
      if (win_pos < 0) begin
         if (iStart) win_pos = 0;
      end else if (win_pos == WINLEN) begin
         msel        = msel ^ 1;
         launch_pend = 1'b1;
         win_pos     = iStart ? 0 : -1;
      end else begin
         win_pos++;
      end
      if (win_pos == 0) begin
         for (int l = 0; l < ODIM; l++) bank[msel][l] = 0;
      end else if (win_pos > 0) begin
         for (int l = 0; l < ODIM; l++)
            if (int'($urandom_range(99)) < bias[l]) bank[msel][l]++;
      end
   endtask

   task automatic cycle(input bit st, input bit rdy, input bit rs);
      @(posedge clk);
      #1;
      model_step();
      chk("acc_sel", longint'(sel_u), longint'(msel));
      chk("acc_sel_b", longint'(sel_b), longint'(msel));
      chk("clear", longint'(clr_u), longint'(win_pos == 0));
      chk("busy", longint'(busy_u), longint'(win_pos != -1));
      chk("busy_b", longint'(busy_b), longint'(win_pos != -1));
      rst    = rs;
      iStart = st;
      iReady = rdy;
      for (int l = 0; l < ODIM; l++) iData[l] = OWID'(bank[msel ^ 1][l]);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("valid", longint'(val_u), longint'(q.size() > 0));
            chk("valid_b", longint'(val_b), longint'(q.size() > 0));
            chk("overrun", longint'(ovr_u), longint'(exp_ovr));
            chk("overrun_b", longint'(ovr_b), longint'(exp_ovr));
            if (q.size() > 0) begin
               chk("idx", longint'(idx_u), longint'(q[0].idx));
               chk("idx_b", longint'(idx_b), longint'(q[0].idx));
               chk("data_uni", longint'(data_u), exp_uni(q[0].cnt));
               chk("data_bip", longint'(data_b), exp_bip(q[0].cnt));
               if (iReady && !rst) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      bit found;
      for (int l = 0; l < ODIM; l++) begin
         iData[l]   = '0;
         bank[0][l] = 0;
         bank[1][l] = 0;
      end
      // Full, half, empty and random lanes hit +W, 0 and -W in bipolar form.
      bias[0] = 100;
      bias[1] = 50;
      bias[2] = 0;
      for (int l = 3; l < ODIM; l++) bias[l] = int'($urandom_range(100));

      cycle(1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      repeat (2) cycle(1'b0, 1'b0, 1'b1);

      // Continuous windows, always ready.
      repeat (40) cycle(1'b1, 1'b1, 1'b0);

      // Ready toggling every cycle.
      for (int i = 0; i < 40; i++) cycle(1'b1, (i % 2) == 1, 1'b0);

      // Drop start while the window counter shows 3.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         if (win_pos == 4) begin
            iStart = 1'b0;
            found  = 1'b1;
         end
      end
      if (!found) timeout("drop_wait");
      repeat (25) cycle(1'b0, 1'b1, 1'b0);
      chk("stop_busy", longint'(busy_u), 0);
      chk("stop_clear", longint'(clr_u), 0);

      // Reset while lane 2 is presented.
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         if (q.size() > 0 && q[0].idx == 2) begin
            rst    = 1'b1;
            iReady = 1'b0;
            found  = 1'b1;
         end
      end
      if (!found) timeout("idx2_wait");
      cycle(1'b1, 1'b1, 1'b0);
      chk("rst_valid", longint'(val_u), 0);
      chk("rst_idx", longint'(idx_u), 0);
      chk("rst_data_u", longint'(data_u), 0);
      chk("rst_data_b", longint'(data_b), 0);
      chk("rst_ovr", longint'(ovr_u), 0);
      chk("rst_sel", longint'(sel_u), 0);
      chk("rst_clear", longint'(clr_u), 0);
      chk("rst_busy", longint'(busy_u), 0);

      // Long stall across a swap forces an overrun and a restart at lane 0.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         if (q.size() > 0 && q[0].idx == 0) found = 1'b1;
      end
      if (!found) timeout("launch_wait");
      repeat (12) cycle(1'b1, 1'b0, 1'b0);
      repeat (30) cycle(1'b1, 1'b1, 1'b0);
      chk("overrun_sticky", longint'(ovr_u), 1);

      // Random ready and occasional start drops.
      for (int i = 0; i < 120; i++)
         cycle(($urandom % 8) != 0, ($urandom % 2) == 1, 1'b0);

      repeat (30) cycle(1'b0, 1'b1, 1'b0);
      chk("drained", longint'(q.size()), 0);
      chk("end_busy", longint'(busy_u), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/buffer_drain_ctrl.md
# buffer_drain_ctrl

Window controller and serial drain stage placed directly downstream of the ping-pong accumulator buffer array. It sequences the accumulate windows by driving the array's bank-select and clear inputs. When a window ends, it reads the frozen bank one lane per transfer and presents each count, optionally converted to bipolar form, on a valid/ready stream to the next layer.

## Interface
Parameters:
- ODIM, 16, number of accumulator lanes.
- OWID, 32, width of each accumulator count.
- WINLEN, 256, number of accumulate cycles per window; must satisfy ODIM <= WINLEN.
- BIPOLAR, 0, 1 selects bipolar output conversion.
- DWID, OWID+1, output data width.

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset; synchronous, active-high.
- iStart  in  1  level enable; windows run while high.
- iData  in  OWID x [ODIM]  counts from the accumulator's read-side output.
- oAccSel  out  1  bank select to the accumulator.
- oClear  out  1  clear to the accumulator.
- oValid  out  1  drain data valid.
- iReady  in  1  downstream ready.
- oIdx  out  $clog2(ODIM)  lane index of oData.
- oData  out  DWID  drained value; signed when BIPOLAR=1.
- oBusy  out  1  window FSM not in IDLE.
- oOverrun  out  1  sticky; a drain was cut short by a swap.

## Operation
- Window FSM states: IDLE, CLEAR, ACC.
  - IDLE -> CLEAR when iStart=1. oAccSel does not change on this transition.
  - CLEAR lasts 1 cycle with oClear=1, then goes to ACC.
  - ACC counts WINLEN cycles (counter 0..WINLEN-1).
  - On the last ACC cycle, the next state is CLEAR if iStart=1, else IDLE. Either way, oAccSel toggles and a drain launches.
- Bank rule: the accumulating bank is cleared and then receives exactly WINLEN bits. After the toggle, the other bank holds the result and is stable for the whole next window, so iData needs no latching.
- Drain FSM states: D_IDLE, D_SEND.
  - A launch sets oIdx=0 and enters D_SEND.
  - The presented value is iData[oIdx], converted and registered.
  - A transfer occurs when oValid && iReady. On a transfer, oIdx increments; after lane ODIM-1, the FSM returns to D_IDLE.
  - oData and oIdx are held stable while oValid && !iReady.
- Conversion:
  - BIPOLAR=0: oData = zero-extended count.
  - BIPOLAR=1: oData = 2*count - WINLEN, computed in DWID signed.
  - Count is guaranteed <= WINLEN, so no saturation is needed.
- Overrun: a new launch arriving while in D_SEND sets oOverrun, which stays high until rst. The drain then restarts at lane 0 on the new bank; the remaining old lanes are dropped.
- iStart falling mid-window: the current window completes, swaps and drains normally, then the FSM goes to IDLE. A stop never truncates a window.

## Timing
- Reset values: oAccSel=0, oClear=0, oValid=0, oIdx=0, oData=0, oBusy=0, oOverrun=0; both FSMs and the window counter at 0.
- rst asserted mid-window or mid-drain aborts everything within 1 cycle, with no final transfer.
- oAccSel, oClear and oBusy are registered.
- oValid rises 1 cycle after the cycle in which oAccSel toggles.
- The first lane can transfer in that same cycle.
- Window period is WINLEN+1 cycles.
- With iReady held high, a full drain takes ODIM cycles, always finishing before the next swap.
- Simultaneous final-lane transfer and new launch: the transfer completes and a new drain starts with no overrun flagged.

## Structure
- Shared package holds:
  - Window FSM enum {IDLE, CLEAR, ACC}.
  - Drain FSM enum {D_IDLE, D_SEND}.
  - Function converting count to bipolar value.
- Natural sub-module: drain_serializer, which contains the index counter, mux, conversion and handshake. The top level keeps the window FSM and counter.

## Test plan
- ODIM=4, WINLEN=8, iStart held, iData fixed at {8,4,0,2}, iReady=1:
  - oClear pulses every 9 cycles and oAccSel alternates.
  - Drain emits 8,4,0,2 with oIdx 0..3 on consecutive cycles.
- Same setup with BIPOLAR=1: drain emits 8,0,-8,-4.
- iReady toggled 1/0 every cycle: each value is held while stalled, there are no duplicates or skips, and oOverrun stays 0.
- iReady=0 for 12 cycles spanning a swap: oOverrun=1 and the drain restarts at oIdx=0 with the new values.
- iStart dropped at window cycle 3: ACC runs to count 7, the swap and drain still occur, then oBusy=0 and no further oClear.
- rst asserted during D_SEND at oIdx=2: the next cycle shows all outputs at their reset values.
